// File: rtl/esm_pkg.sv
// Shared ESM definitions: control-message constants, the per-word config
// broadcast record and the parser state encoding.
package esm_pkg;

    localparam logic [31:0] esm_control_magic_num                 = 32'h45534D43;
    localparam logic [7:0]  esm_module_id_common                  = 8'h00;
    localparam logic [7:0]  esm_module_id_dwell_controller        = 8'h01;
    localparam logic [7:0]  esm_control_message_type_enable       = 8'h00;
    localparam logic [7:0]  esm_control_message_type_dwell_entry  = 8'h01;
    localparam logic [7:0]  esm_control_message_type_dwell_program = 8'h02;

    typedef struct packed {
        logic        valid;
        logic        first;
        logic        last;
        logic [7:0]  module_id;
        logic [7:0]  message_type;
        logic [31:0] data;
    } esm_config_data_t;

    typedef enum logic [2:0] {
        S_MAGIC   = 3'd0,
        S_SEQ     = 3'd1,
        S_HEADER  = 3'd2,
        S_PAYLOAD = 3'd3,
        S_DROP    = 3'd4
    } esm_cfg_state_e;

    // True when the header addresses the common block's enable register.
    function automatic logic is_common_enable(input logic [7:0] module_id,
                                              input logic [7:0] message_type);
        return (module_id == esm_module_id_common) &&
               (message_type == esm_control_message_type_enable);
    endfunction

endpackage

// File: rtl/esm_config.sv
// ESM control-message parser. Accepts one config word per valid beat,
// checks the magic word, latches sequence and header, then either applies
// the common enable word locally or broadcasts payload words to modules.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_MAGIC   | expecting word0; compared against the magic number
// S_SEQ     | expecting word1; sequence number, stored but not checked
// S_HEADER  | expecting word2; module_id / message_type decode
// S_PAYLOAD | payload words until the beat carrying Axis_last
// S_DROP    | bad magic; discard words until the beat carrying Axis_last
module esm_config
    import esm_pkg::*;
#(
    parameter int AXI_DATA_WIDTH = 32
) (
    input  logic                      Clk,
    input  logic                      Rst_n,
    output logic                      Axis_ready,
    input  logic                      Axis_valid,
    input  logic                      Axis_last,
    input  logic [AXI_DATA_WIDTH-1:0] Axis_data,
    output logic                      Rst_out,
    output logic [1:0]                Enable_chan,
    output logic [1:0]                Enable_pdw,
    output esm_config_data_t          Module_config
);

    esm_cfg_state_e   state_q, state_d;
    logic [31:0]      seq_q, seq_d;
    logic [7:0]       hdr_mid_q, hdr_mid_d;
    logic [7:0]       hdr_mt_q, hdr_mt_d;
    logic             first_q, first_d;
    logic             rst_out_q, rst_out_d;
    logic [1:0]       en_chan_q, en_chan_d;
    logic [1:0]       en_pdw_q, en_pdw_d;
    esm_config_data_t cfg_q, cfg_d;

    logic [31:0] word;
    logic        accept;

    // The stream never back-pressures; ready simply follows reset release so
    // a word arriving on the first cycle out of reset is taken as a magic.
    assign Axis_ready = Rst_n;
    assign accept     = Axis_valid & Axis_ready;
    assign word       = Axis_data[31:0];

    // State register plus the per-message context (sequence, header, first flag).
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q   <= S_MAGIC;
            seq_q     <= '0;
            hdr_mid_q <= '0;
            hdr_mt_q  <= '0;
            first_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            seq_q     <= seq_d;
            hdr_mid_q <= hdr_mid_d;
            hdr_mt_q  <= hdr_mt_d;
            first_q   <= first_d;
        end
    end

    // Next-state and context update; nothing moves unless a beat is accepted,
    // so X on idle cycles cannot leak into the parser.
    always_comb begin
        state_d   = state_q;
        seq_d     = seq_q;
        hdr_mid_d = hdr_mid_q;
        hdr_mt_d  = hdr_mt_q;
        first_d   = first_q;
        if (accept) begin
            case (state_q)
                S_MAGIC: begin
                    if (Axis_last)
                        state_d = S_MAGIC;
                    else if (word == esm_control_magic_num)
                        state_d = S_SEQ;
                    else
                        state_d = S_DROP;
                end
                S_SEQ: begin
                    seq_d   = word;
                    state_d = Axis_last ? S_MAGIC : S_HEADER;
                end
                S_HEADER: begin
                    hdr_mid_d = word[31:24];
                    hdr_mt_d  = word[23:16];
                    first_d   = 1'b1;
                    state_d   = Axis_last ? S_MAGIC : S_PAYLOAD;
                end
                S_PAYLOAD: begin
                    first_d = 1'b0;
                    state_d = Axis_last ? S_MAGIC : S_PAYLOAD;
                end
                S_DROP: begin
                    state_d = Axis_last ? S_MAGIC : S_DROP;
                end
                default: begin
                    state_d = S_MAGIC;
                end
            endcase
        end
    end

    // Output decode: the first common-enable payload word updates the local
    // enables; payload for any other module is broadcast as a one-cycle pulse.
    always_comb begin
        rst_out_d   = rst_out_q;
        en_chan_d   = en_chan_q;
        en_pdw_d    = en_pdw_q;
        cfg_d       = cfg_q;
        cfg_d.valid = 1'b0;
        if (accept && (state_q == S_PAYLOAD)) begin
            if (hdr_mid_q == esm_module_id_common) begin
                if (is_common_enable(hdr_mid_q, hdr_mt_q) && first_q) begin
                    rst_out_d = word[0];
                    en_chan_d = word[9:8];
                    en_pdw_d  = word[17:16];
                end
            end else begin
                cfg_d.valid        = 1'b1;
                cfg_d.first        = first_q;
                cfg_d.last         = Axis_last;
                cfg_d.module_id    = hdr_mid_q;
                cfg_d.message_type = hdr_mt_q;
                cfg_d.data         = word;
            end
        end
    end

    // Registered outputs; downstream blocks are held in reset until configured.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            rst_out_q <= 1'b1;
            en_chan_q <= '0;
            en_pdw_q  <= '0;
            cfg_q     <= '0;
        end else begin
            rst_out_q <= rst_out_d;
            en_chan_q <= en_chan_d;
            en_pdw_q  <= en_pdw_d;
            cfg_q     <= cfg_d;
        end
    end

    assign Rst_out       = rst_out_q;
    assign Enable_chan   = en_chan_q;
    assign Enable_pdw    = en_pdw_q;
    assign Module_config = cfg_q;

endmodule

// File: tb/tb_esm_config.sv
// Bench for esm_config: directed messages followed by randomized traffic,
// each beat checked against a word-index model of the message format.
module tb_esm_config;
    import esm_pkg::*;

    logic             Clk = 1'b0;
    logic             Rst_n;
    logic             Axis_ready;
    logic             Axis_valid;
    logic             Axis_last;
    logic [31:0]      Axis_data;
    logic             Rst_out;
    logic [1:0]       Enable_chan;
    logic [1:0]       Enable_pdw;
    esm_config_data_t Module_config;

    esm_config #(.AXI_DATA_WIDTH(32)) dut (
        .Clk          (Clk),
        .Rst_n        (Rst_n),
        .Axis_ready   (Axis_ready),
        .Axis_valid   (Axis_valid),
        .Axis_last    (Axis_last),
        .Axis_data    (Axis_data),
        .Rst_out      (Rst_out),
        .Enable_chan  (Enable_chan),
        .Enable_pdw   (Enable_pdw),
        .Module_config(Module_config)
    );

    always #5 Clk = ~Clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: position of the next word within its message plus
    // what has been learned from the header so far.
    int               m_idx = 0;
    bit               m_ok = 1'b0;
    logic [7:0]       m_mid = 8'h00;
    logic [7:0]       m_mt = 8'h00;
    logic             exp_rst = 1'b1;
    logic [1:0]       exp_chan = 2'd0;
    logic [1:0]       exp_pdw = 2'd0;
    logic             exp_pulse = 1'b0;
    esm_config_data_t exp_cfg = '0;
    int               obs_pulses = 0;
    int               exp_pulses = 0;

    logic [31:0] msg_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outs();
        chk("ready", 64'(Axis_ready), 64'(1'b1));
        chk("rst_out", 64'(Rst_out), 64'(exp_rst));
        chk("enable_chan", 64'(Enable_chan), 64'(exp_chan));
        chk("enable_pdw", 64'(Enable_pdw), 64'(exp_pdw));
        chk("cfg_valid", 64'(Module_config.valid), 64'(exp_pulse));
        if (exp_pulse)
            chk("cfg_word", 64'(Module_config), 64'(exp_cfg));
        if (Module_config.valid === 1'b1) obs_pulses++;
        if (exp_pulse) exp_pulses++;
    endtask

    task automatic send_beat(input logic [31:0] w, input logic last);
        @(negedge Clk);
        Axis_valid = 1'b1;
        Axis_data  = w;
        Axis_last  = last;
        exp_pulse  = 1'b0;
        if (m_idx == 0) begin
            m_ok = (w == esm_control_magic_num);
        end else if (m_idx == 2 && m_ok) begin
            m_mid = w[31:24];
            m_mt  = w[23:16];
        end else if (m_idx >= 3 && m_ok) begin
            if (m_mid == 8'h00) begin
                if (m_mt == 8'h00 && m_idx == 3) begin
                    exp_rst  = w[0];
                    exp_chan = w[9:8];
                    exp_pdw  = w[17:16];
                end
            end else begin
                exp_pulse            = 1'b1;
                exp_cfg.valid        = 1'b1;
                exp_cfg.first        = (m_idx == 3);
                exp_cfg.last         = last;
                exp_cfg.module_id    = m_mid;
                exp_cfg.message_type = m_mt;
                exp_cfg.data         = w;
            end
        end
        m_idx = last ? 0 : m_idx + 1;
        @(posedge Clk);
        #1;
        check_outs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge Clk);
            Axis_valid = 1'b0;
            Axis_data  = 'x;
            Axis_last  = 1'bx;
            exp_pulse  = 1'b0;
            @(posedge Clk);
            #1;
            check_outs();
        end
    endtask

    task automatic send_msg(input bit gaps);
        for (int i = 0; i < msg_q.size(); i++) begin
            if (gaps && $urandom_range(0, 3) == 0) idle(1);
            send_beat(msg_q[i], (i == msg_q.size() - 1));
        end
    endtask

    task automatic do_reset();
        #2;
        Rst_n      = 1'b0;
        Axis_valid = 1'b0;
        Axis_last  = 1'bx;
        Axis_data  = 'x;
        #1;
        exp_rst   = 1'b1;
        exp_chan  = 2'd0;
        exp_pdw   = 2'd0;
        exp_pulse = 1'b0;
        m_idx     = 0;
        m_ok      = 1'b0;
        chk("rst_ready", 64'(Axis_ready), 64'(1'b0));
        chk("rst_rst_out", 64'(Rst_out), 64'(1'b1));
        chk("rst_chan", 64'(Enable_chan), 64'(2'd0));
        chk("rst_pdw", 64'(Enable_pdw), 64'(2'd0));
        chk("rst_cfg", 64'(Module_config), 64'(0));
        repeat (2) @(negedge Clk);
        Rst_n = 1'b1;
    endtask

    task automatic build_random();
        int          npay;
        int          total;
        logic [7:0]  mid;
        logic [7:0]  mt;
        logic [31:0] w;
        msg_q.delete();
        mid   = 8'($urandom_range(0, 2));
        mt    = 8'($urandom_range(0, 2));
        npay  = $urandom_range(0, 5);
        total = 3 + npay;
        if ($urandom_range(0, 7) == 0) total = $urandom_range(1, 3);
        for (int i = 0; i < total; i++) begin
            case (i)
                0: w = ($urandom_range(0, 9) == 0) ? 32'($urandom) : esm_control_magic_num;
                1: w = 32'($urandom);
                2: w = {mid, mt, 16'($urandom)};
                default: w = 32'($urandom);
            endcase
            msg_q.push_back(w);
        end
    endtask

    initial begin
        Rst_n      = 1'b1;
        Axis_valid = 1'b0;
        Axis_last  = 1'b0;
        Axis_data  = '0;
        do_reset();

        // Common enable message.
        msg_q = '{esm_control_magic_num, 32'h0, 32'h0000_0000, 32'h0003_0300};
        send_msg(1'b0);
        chk("common_chan", 64'(Enable_chan), 64'(2'd3));
        chk("common_pdw", 64'(Enable_pdw), 64'(2'd3));
        chk("common_rst", 64'(Rst_out), 64'(1'b0));
        idle(2);

        // Dwell-entry message with eight payload words.
        msg_q = '{esm_control_magic_num, 32'h1, 32'h0101_0000};
        for (int i = 0; i < 8; i++) msg_q.push_back(32'($urandom));
        send_msg(1'b0);
        idle(1);

        // Bad magic followed by four words, then a good common message.
        msg_q = '{32'hDEAD_BEEF, 32'h0003_0301, 32'h0000_0000, 32'h0003_0301, 32'h1234_5678};
        send_msg(1'b0);
        msg_q = '{esm_control_magic_num, 32'h7, 32'h0000_ABCD, 32'h0001_0201, 32'h0000_0000};
        send_msg(1'b0);
        idle(1);

        // Header-only message.
        msg_q = '{esm_control_magic_num, 32'h5, 32'h0101_0000};
        send_msg(1'b0);
        msg_q = '{esm_control_magic_num, 32'h6, 32'h0000_0000};
        send_msg(1'b0);
        idle(1);

        // Reset in the middle of a dwell-program payload.
        send_beat(esm_control_magic_num, 1'b0);
        send_beat(32'h2, 1'b0);
        send_beat(32'h0102_0000, 1'b0);
        send_beat(32'hAAAA_5555, 1'b0);
        send_beat(32'h5555_AAAA, 1'b0);
        do_reset();
        msg_q = '{esm_control_magic_num, 32'h9, 32'h0101_0000, 32'hCAFE_0001, 32'hCAFE_0002};
        send_msg(1'b0);
        idle(1);

        // Two messages back-to-back, valid held high throughout.
        obs_pulses = 0;
        exp_pulses = 0;
        msg_q = '{esm_control_magic_num, 32'h10, 32'h0101_0000, 32'h1111_0000, 32'h2222_0000, 32'h3333_0000};
        send_msg(1'b0);
        msg_q = '{esm_control_magic_num, 32'h11, 32'h0102_0000, 32'h4444_0000, 32'h5555_0000};
        send_msg(1'b0);
        idle(1);
        chk("b2b_pulses", 64'(obs_pulses), 64'(exp_pulses));

        // Randomized traffic with random gaps and truncated messages.
        for (int n = 0; n < 60; n++) begin
            build_random();
            send_msg(($urandom_range(0, 1) == 1));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
